// File: rtl/counter_pkg.sv
// Shared types and constants for the modulo-N up/down counter.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_next_value.sv
// Combinational step logic: computes the wrapped next count for the current
// direction and flags when the count sits on the terminal value.
module counter_next_value
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] next_count,
    output logic             is_tv
);

    always_comb begin
        if (up_down == DIR_UP) begin
            is_tv      = (count == max_val);
            next_count = is_tv ? '0 : count + 1'b1;
        end else begin
            is_tv      = (count == '0);
            next_count = is_tv ? max_val : count - 1'b1;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, wrap pulse and one-shot FSM.
// Build option COUNTER_SATURATE_EN: free-run steps hold at the terminal value.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             one_shot,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output state_t           fsm_state
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] step_value;
    logic [WIDTH-1:0] load_clipped;
    logic             is_tv;
    logic             wrap_next;

    counter_next_value #(.WIDTH(WIDTH)) u_next (
        .count      (count),
        .up_down    (up_down),
        .max_val    (MAX_VAL),
        .next_count (step_value),
        .is_tv      (is_tv)
    );

    assign load_clipped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    assign tc           = is_tv;
    assign fsm_state    = state;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: load alone never moves the FSM; start always (re)enters RUN
    always_comb begin
        state_next = state;
        if (!one_shot) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RUN;
        end else if (!load && enable && state == RUN && is_tv) begin
            state_next = DONE;
        end
    end

    // FSM outputs
    always_comb begin
        done = (state == DONE);
    end

    // Count datapath, priority load > start > step
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_clipped;
        end else if (!one_shot) begin
            if (enable) begin
`ifdef COUNTER_SATURATE_EN
                if (!is_tv) begin
                    count_next = step_value;
                end
`else
                count_next = step_value;
                wrap_next  = is_tv;
`endif
            end
        end else if (start) begin
            if (state == DONE) begin
                count_next = (up_down == DIR_UP) ? '0 : MAX_VAL;
            end
        end else if (enable && state == RUN && !is_tv) begin
            count_next = step_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed checks of mod_updown_counter (WIDTH=4, MODULUS=10)
// against an arithmetic reference model.
module tb_mod_updown_counter;
    import counter_pkg::*;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
    localparam int MAXV    = MODULUS - 1;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             one_shot;
    logic             start;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             done;
    state_t           fsm_state;

    int checks   = 0;
    int failures = 0;

    int     m_count;
    int     m_wrap;
    state_t m_state;

    mod_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .up_down    (up_down),
        .load       (load),
        .load_value (load_value),
        .one_shot   (one_shot),
        .start      (start),
        .count      (count),
        .tc         (tc),
        .wrap       (wrap),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_of(input int c, input logic up);
        return up ? (c + 1) % MODULUS : (c + MODULUS - 1) % MODULUS;
    endfunction

    // Reference model: advance one clock edge from the current inputs.
    task automatic model_edge();
        int     nc;
        int     nw;
        int     clipped;
        bit     at_tv;
        state_t ns;
        nc      = m_count;
        nw      = 0;
        ns      = m_state;
        at_tv   = up_down ? (m_count == MAXV) : (m_count == 0);
        clipped = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
        if (!one_shot) begin
            ns = IDLE;
            if (load) begin
                nc = clipped;
            end else if (enable) begin
`ifdef COUNTER_SATURATE_EN
                nc = at_tv ? m_count : step_of(m_count, up_down);
`else
                nc = step_of(m_count, up_down);
                nw = at_tv ? 1 : 0;
`endif
            end
        end else begin
            if (load) begin
                nc = clipped;
                if (start) ns = RUN;
            end else if (start) begin
                if (m_state == DONE) nc = up_down ? 0 : MAXV;
                ns = RUN;
            end else if (enable && m_state == RUN) begin
                if (at_tv) ns = DONE;
                else nc = step_of(m_count, up_down);
            end
        end
        m_count = nc;
        m_wrap  = nw;
        m_state = ns;
    endtask

    task automatic check_outputs(input string tag);
        int exp_tc;
        exp_tc = up_down ? int'(m_count == MAXV) : int'(m_count == 0);
        check_eq({tag, ".count"}, int'(count), m_count);
        check_eq({tag, ".wrap"}, int'(wrap), m_wrap);
        check_eq({tag, ".done"}, int'(done), int'(m_state == DONE));
        check_eq({tag, ".state"}, int'(fsm_state), int'(m_state));
        check_eq({tag, ".tc"}, int'(tc), exp_tc);
    endtask

    // One clock: inputs are already driven; update model at the edge, check after.
    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic en, input logic ud, input logic ld,
                         input int lv, input logic os, input logic st);
        enable     = en;
        up_down    = ud;
        load       = ld;
        load_value = WIDTH'(lv);
        one_shot   = os;
        start      = st;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1, 0, 0, 0, 0);
        m_count = 0;
        m_wrap  = 0;
        m_state = IDLE;
        #3;
        check_outputs("reset");
        reset = 1'b0;

        // Free-run up through a wrap
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick("up_run");

        // Down from 0 wraps to MAX
        drive(0, 0, 1, 0, 0, 0);
        tick("load0");
        check_eq("tc_at_zero_down", int'(tc), 1);
        drive(1, 0, 0, 0, 0, 0);
        tick("down_wrap");
        check_eq("down_wrap_count", int'(count), MAXV);
        drive(0, 0, 0, 0, 0, 0);
        tick("down_wrap_pulse");
        check_eq("down_wrap_wrap", int'(wrap), 0);

        // Load clipping and load-over-enable priority
        drive(0, 1, 1, 12, 0, 0);
        tick("load_clip");
        check_eq("load_clip_count", int'(count), MAXV);
        drive(1, 1, 1, 3, 0, 0);
        tick("load_wins");
        check_eq("load_wins_count", int'(count), 3);

        // One-shot run to DONE, then restart
        drive(0, 1, 0, 0, 1, 1);
        tick("os_start");
        drive(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 11; i++) tick("os_run");
        check_eq("os_done", int'(done), 1);
        check_eq("os_hold", int'(count), MAXV);
        drive(0, 1, 0, 0, 1, 1);
        tick("os_restart");
        check_eq("os_restart_count", int'(count), 0);
        check_eq("os_restart_state", int'(fsm_state), int'(RUN));

        // Asynchronous reset between edges at count 6
        drive(0, 1, 1, 6, 1, 1);
        tick("pre_reset");
        drive(0, 1, 0, 0, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        m_count = 0;
        m_wrap  = 0;
        m_state = IDLE;
        check_eq("async_count", int'(count), 0);
        check_eq("async_done", int'(done), 0);
        check_eq("async_state", int'(fsm_state), int'(IDLE));
        #1;
        reset = 1'b0;

`ifdef COUNTER_SATURATE_EN
        drive(0, 1, 1, 8, 0, 0);
        tick("sat_load");
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("sat_up");
        check_eq("sat_count", int'(count), MAXV);
        check_eq("sat_tc", int'(tc), 1);
`endif

        // Randomised mix of modes and requests
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) one_shot = ~one_shot;
            enable     = ($urandom_range(0, 9) < 7);
            up_down    = ($urandom_range(0, 3) != 0) ? up_down : ~up_down;
            load       = ($urandom_range(0, 9) == 0);
            load_value = WIDTH'($urandom_range(0, 15));
            start      = ($urandom_range(0, 11) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
